// File: rtl/disp_value_fmt_pkg.sv
// Shared types and constants for the HEX display value formatter.
// Holds FSM state encoding, digit count default and the decimal range limit.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int unsigned DISP_NDIG = 6;
  localparam logic [3:0]  OVF_DIGIT = 4'hF;

  // Largest value representable on ndig decimal digits (10^ndig - 1).
  function automatic longint unsigned dec_max(input int unsigned ndig);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < ndig; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam longint unsigned DEC_MAX = dec_max(DISP_NDIG);

endpackage

// File: rtl/disp_value_fmt_bcd_add3.sv
// Double-dabble nibble correction: values of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/disp_value_fmt.sv
// Binary-to-display formatter: hex nibble split or iterative double-dabble
// conversion, one bit per cycle, with registered digit/enchx/ovf outputs.
module disp_value_fmt
  import disp_pkg::*;
#(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned NDIG  = DISP_NDIG
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  input  logic                hex_mode,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   digits,
  output logic                enchx,
  output logic                ovf
);

  localparam int unsigned     DW    = 4 * NDIG;
  localparam int unsigned     CW    = $clog2(WIDTH + 1);
  localparam longint unsigned WMAX  = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned DMAX  = dec_max(NDIG);
  localparam longint unsigned LIM_L = (DMAX < WMAX) ? DMAX : WMAX;
  localparam logic [WIDTH-1:0] LIMIT = LIM_L[WIDTH-1:0];

  state_t              state, nstate;
  logic [WIDTH-1:0]    shreg;
  logic [DW-1:0]       bcd;
  logic [CW-1:0]       cnt;

  logic [DW-1:0]       bcd_adj;
  logic [DW+WIDTH-1:0] cat;
  logic [DW+WIDTH-1:0] cat_sh;
  logic [DW-1:0]       bcd_next;
  logic [WIDTH-1:0]    sh_next;
  logic                last_shift;
  logic                out_of_range;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    cat          = {bcd_adj, shreg};
    cat_sh       = cat << 1;
    bcd_next     = cat_sh[DW+WIDTH-1:WIDTH];
    sh_next      = cat_sh[WIDTH-1:0];
    last_shift   = (cnt == CW'(1));
    out_of_range = (value > LIMIT);
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (start) begin
          nstate = (hex_mode || out_of_range) ? DONE : CONV;
        end
      end
      CONV:    if (last_shift) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs are loaded on the edge that enters DONE, so the done pulse and
  // the new result appear together and nothing intermediate is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      digits <= '0;
      enchx  <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= nstate;
      done  <= (nstate == DONE);
      busy  <= (nstate != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= value;
            bcd   <= '0;
            cnt   <= CW'(WIDTH);
            if (hex_mode) begin
              digits <= DW'(value);
              enchx  <= 1'b1;
              ovf    <= 1'b0;
            end else if (out_of_range) begin
              digits <= {NDIG{OVF_DIGIT}};
              enchx  <= 1'b0;
              ovf    <= 1'b1;
            end
          end
        end
        CONV: begin
          shreg <= sh_next;
          bcd   <= bcd_next;
          cnt   <= cnt - CW'(1);
          if (last_shift) begin
            digits <= bcd_next;
            enchx  <= 1'b0;
            ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/disp_value_fmt.md
Name: disp_value_fmt

Overview:
Sequential formatter upstream of the per-digit 7-segment encoders on the DE1-SoC HEX display bank. It accepts a binary value with a start pulse and, per request, produces NDIG 4-bit digit codes plus a hex-enable flag. Decimal requests use an iterative double-dabble conversion, one bit per cycle. Hex requests are split directly into nibbles. Each digit slice and the enchx flag feed one encoder instance directly.

Parameters:
WIDTH, 20, bit width of input value (must satisfy 2^WIDTH <= 16^NDIG)
NDIG, 6, number of display digits (4*NDIG-bit digit bus)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
value  in  WIDTH  binary value, sampled on accepted start
hex_mode  in  1  1 = hex nibble split, 0 = decimal conversion; sampled with value
busy  out  1  high from accepted start until the cycle done is high, inclusive
done  out  1  one-cycle pulse; digits/enchx/ovf updated in the same cycle
digits  out  4*NDIG  digit codes, digit 0 in [3:0]; registered, stable between done pulses
enchx  out  1  1 = digits are hex (codes 10..15 legal), 0 = decimal
ovf  out  1  last result overflowed the display range

Behaviour:
- Reset (async assert, sync-released by system): state=IDLE; digits=0, enchx=0, ovf=0, busy=0, done=0. Reset mid-conversion abandons the conversion; no done pulse follows.
- States: IDLE, CONV, DONE.
- IDLE + start: latch value into shift reg, bcd accumulator=0, mode=hex_mode, cnt=WIDTH; busy=1 next cycle.
  - hex_mode=1 -> DONE. Result digits = value zero-extended to 4*NDIG, enchx=1, ovf=0.
  - hex_mode=0 and value > 10^NDIG-1 -> DONE. Result digits = all 4'hF, enchx=0, ovf=1 (the encoder renders its bar pattern on every digit).
  - hex_mode=0 and value in range -> CONV.
- CONV: per cycle, each bcd nibble >= 5 gets +3, then {bcd, shreg} shifts left by 1 and cnt decrements. After the WIDTH-th shift -> DONE. Result digits = bcd, enchx=0, ovf=0.
- DONE: output registers load the result; done=1 for exactly this cycle; busy=1; next state IDLE.
- Latency from the start-sampling edge to done high:
  - hex or overflow: 1 cycle
  - decimal: WIDTH+1 cycles (21 at defaults)
- start while busy (CONV or DONE): ignored, never queued. A new start is accepted earliest the cycle after done.
- value/hex_mode changes after acceptance: no effect.
- Outputs hold the previous result during a conversion; no intermediate values are ever visible.
- Arithmetic:
  - bcd accumulator is 4*NDIG bits; add-3 is applied per nibble before the shift.
  - Range check compares against the WIDTH-bit constant min(10^NDIG-1, 2^WIDTH-1).
- Boundaries:
  - value=0 -> all-zero digits.
  - value=10^NDIG-1 -> all 9s, ovf=0.
  - value=10^NDIG -> overflow pattern.

Decomposition:
- Package disp_pkg holds:
  - state enum (IDLE, CONV, DONE)
  - DISP_NDIG=6
  - DEC_MAX function/constant (10^NDIG-1)
  - OVF_DIGIT=4'hF
- Sub-module bcd_add3: combinational 4-bit correction (in>=5 ? in+3 : in), instantiated NDIG times in a generate loop.

Test Plan:
- Reset: hold rst_n=0, then release; digits=0, enchx=0, ovf=0, busy=0, done=0. Assert rst_n low mid-CONV: all outputs return to reset values immediately and no done pulse follows.
- Decimal: start, value=123456, hex_mode=0 -> done at cycle 21, digits=24'h123456, enchx=0, ovf=0; busy high cycles 1..21.
- Hex: start, value=20'hABCDF, hex_mode=1 -> done at cycle 1, digits=24'h0ABCDF, enchx=1, ovf=0.
- Decimal boundaries:
  - value=0 -> 24'h000000
  - value=999999 -> 24'h999999, ovf=0
  - value=1000000 -> done at cycle 1, digits=24'hFFFFFF, enchx=0, ovf=1
- Busy handling: start with value=42 (decimal), then pulse start with value=7 at cycles 5 and 21 -> single done, digits=24'h000042. Start at cycle 22 accepted -> 24'h000007.
- Output stability: during a conversion, digits keep the prior result every cycle until done; done is high for exactly one cycle per accepted start (checked over 1000 random starts against a reference model).
